// File: rtl/pinaipple_chip_emu_if.sv
// Chip pad bus between the SoC accelerator port (master) and the PinAIpple chip emulator (slave).
interface pinaipple_chip_emu_if #(
   parameter int NARRAY = 2,
   parameter int NWORD  = 3,
   parameter int NROW   = 5
);
   logic [1:0]              instructions_in;
   logic [NARRAY+NWORD-1:0] adr_full_col_in;
   logic [NROW-1:0]         adr_full_row_in;
   logic                    CBL;
   logic                    CBLEN;
   logic                    CSL;
   logic                    CWL;
   logic                    DATA_out [2**NARRAY];
   logic                    busy_o;
   logic                    prog_err_o;

   modport master (
      output instructions_in, adr_full_col_in, adr_full_row_in, CBL, CBLEN, CSL, CWL,
      input  DATA_out, busy_o, prog_err_o
   );

   modport slave (
      input  instructions_in, adr_full_col_in, adr_full_row_in, CBL, CBLEN, CSL, CWL,
      output DATA_out, busy_o, prog_err_o
   );
endinterface

// File: rtl/pinaipple_chip_emu.sv
// FPGA stand-in for the PinAIpple memory/inference chip: non-volatile cell array with
// form/program pulses, parallel per-lane memory read and popcount-threshold inference.
module pinaipple_chip_emu #(
   parameter int NARRAY    = 2,
   parameter int NWORD     = 3,
   parameter int NROW      = 5,
   parameter int PULSE_MIN = 3,
   parameter int READ_LAT  = 2,
   parameter int THRESH    = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   pinaipple_chip_emu_if.slave bus
);
   localparam int LANES = 2**NARRAY;
   localparam int COLS  = 2**NWORD;
   localparam int ROWS  = 2**NROW;
   localparam logic [7:0]       CNT_MAX     = 8'hFF;
   localparam logic [7:0]       PULSE_MIN_C = 8'(PULSE_MIN);
   localparam logic [7:0]       READ_INIT_C = 8'(READ_LAT - 1);
   localparam logic [31:0]      THRESH_C    = 32'(THRESH);
   localparam logic [NWORD-1:0] COL_LAST    = NWORD'(COLS - 1);
   localparam logic [NWORD-1:0] COL_ONE     = NWORD'(1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PULSE = 3'd1,
      ST_READ  = 3'd2,
      ST_INFER = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t              state_r, state_nx_s;
   logic [7:0]          cnt_r, cnt_nx_s;
   logic [NARRAY-1:0]   lane_r, lane_nx_s;
   logic [NWORD-1:0]    col_r, col_nx_s;
   logic [NROW-1:0]     row_r, row_nx_s;
   logic [NWORD-1:0]    icol_r, icol_nx_s;
   logic [NWORD:0]      acc_r    [LANES];
   logic [NWORD:0]      acc_nx_s [LANES];
   logic [LANES-1:0]    out_r, out_nx_s;
   logic [LANES-1:0]    dout_r, dout_nx_s;
   logic                err_r, err_nx_s;
   logic                busy_r;
   logic                wr_form_s, wr_prog_s;

   // Non-volatile array: powers up zero on the FPGA and is deliberately outside the reset domain.
   logic [COLS-1:0]     mem_r    [LANES][ROWS];
   logic [COLS-1:0]     formed_r [LANES][ROWS];

   // Next-state and datapath decode for the chip sequencer.
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      lane_nx_s  = lane_r;
      col_nx_s   = col_r;
      row_nx_s   = row_r;
      icol_nx_s  = icol_r;
      acc_nx_s   = acc_r;
      out_nx_s   = out_r;
      dout_nx_s  = dout_r;
      err_nx_s   = err_r;
      wr_form_s  = 1'b0;
      wr_prog_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            lane_nx_s = bus.adr_full_col_in[NARRAY+NWORD-1:NWORD];
            col_nx_s  = bus.adr_full_col_in[NWORD-1:0];
            row_nx_s  = bus.adr_full_row_in;
            if (bus.CWL && (bus.instructions_in == 2'b11) && bus.CBLEN) begin
               state_nx_s = ST_PULSE;
               cnt_nx_s   = 8'd1;
            end else if (bus.instructions_in == 2'b10) begin
               state_nx_s = ST_READ;
               cnt_nx_s   = READ_INIT_C;
            end else if (bus.instructions_in == 2'b00) begin
               state_nx_s = ST_INFER;
               icol_nx_s  = '0;
               for (int k = 0; k < LANES; k++) acc_nx_s[k] = '0;
            end else if (bus.instructions_in == 2'b01) begin
               dout_nx_s = out_r;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_PULSE: begin
            if (bus.CWL) begin
               if (cnt_r != CNT_MAX) cnt_nx_s = cnt_r + 8'd1;
               else                  cnt_nx_s = cnt_r;
            end else begin
               state_nx_s = ST_DONE;
               if (cnt_r < PULSE_MIN_C)                 err_nx_s  = 1'b1;
               else if (bus.CSL)                        wr_form_s = 1'b1;
               else if (formed_r[lane_r][row_r][col_r]) wr_prog_s = 1'b1;
               else                                     err_nx_s  = 1'b1;
            end
         end
         ST_READ: begin
            if (cnt_r == 8'd0) begin
               for (int k = 0; k < LANES; k++) out_nx_s[k] = mem_r[k][row_r][col_r];
               state_nx_s = ST_DONE;
            end else begin
               cnt_nx_s = cnt_r - 8'd1;
            end
         end
         ST_INFER: begin
            for (int k = 0; k < LANES; k++)
               acc_nx_s[k] = acc_r[k] + {{NWORD{1'b0}}, mem_r[k][row_r][icol_r]};
            if (icol_r == COL_LAST) begin
               for (int k = 0; k < LANES; k++) out_nx_s[k] = (32'(acc_nx_s[k]) >= THRESH_C);
               state_nx_s = ST_DONE;
            end else begin
               icol_nx_s = icol_r + COL_ONE;
            end
         end
         ST_DONE: begin
            dout_nx_s  = out_r;
            state_nx_s = ST_IDLE;
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Sequencer state, counters and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= ST_IDLE;
         cnt_r   <= 8'd0;
         lane_r  <= '0;
         col_r   <= '0;
         row_r   <= '0;
         icol_r  <= '0;
         for (int k = 0; k < LANES; k++) acc_r[k] <= '0;
         out_r   <= '0;
         dout_r  <= '0;
         err_r   <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
         lane_r  <= lane_nx_s;
         col_r   <= col_nx_s;
         row_r   <= row_nx_s;
         icol_r  <= icol_nx_s;
         acc_r   <= acc_nx_s;
         out_r   <= out_nx_s;
         dout_r  <= dout_nx_s;
         err_r   <= err_nx_s;
         busy_r  <= (state_nx_s != ST_IDLE);
      end
   end

   // Cell writes; a reset drops the FSM to IDLE so an in-flight pulse never commits.
   always_ff @(posedge clk_i) begin
      if (wr_form_s) begin
         formed_r[lane_r][row_r][col_r] <= 1'b1;
         mem_r[lane_r][row_r][col_r]    <= 1'b0;
      end else if (wr_prog_s) begin
         mem_r[lane_r][row_r][col_r]    <= bus.CBL;
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_dout
      assign bus.DATA_out[k] = dout_r[k];
   end
   assign bus.busy_o     = busy_r;
   assign bus.prog_err_o = err_r;
endmodule
